// File: rtl/sram_arb_if.sv
// Requester, SRAM-controller and completion signals of the two-port SRAM arbiter.
// The slave modport is the arbiter; the master modport is the environment around it.
interface sram_arb_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16
);
    logic              iReq0;
    logic              iReq1;
    logic              iWrite0;
    logic              iWrite1;
    logic [ADDR_W-1:0] iAddr0;
    logic [ADDR_W-1:0] iAddr1;
    logic [DATA_W-1:0] iWrData0;
    logic [DATA_W-1:0] iWrData1;
    logic              oGnt0;
    logic              oGnt1;
    logic              oDone0;
    logic              oDone1;
    logic              oErr;
    logic [DATA_W-1:0] oRdData;
    logic [ADDR_W-1:0] oAddress;
    logic [DATA_W-1:0] oWrData;
    logic              oWrite;
    logic              oValidRequest;
    logic              iValidRead;
    logic [DATA_W-1:0] iRdData;

    modport slave (
        input  iReq0, iReq1, iWrite0, iWrite1, iAddr0, iAddr1, iWrData0, iWrData1,
        input  iValidRead, iRdData,
        output oGnt0, oGnt1, oDone0, oDone1, oErr, oRdData,
        output oAddress, oWrData, oWrite, oValidRequest
    );

    modport master (
        output iReq0, iReq1, iWrite0, iWrite1, iAddr0, iAddr1, iWrData0, iWrData1,
        output iValidRead, iRdData,
        input  oGnt0, oGnt1, oDone0, oDone1, oErr, oRdData,
        input  oAddress, oWrData, oWrite, oValidRequest
    );
endinterface

// File: rtl/sram_arb.sv
// Round-robin arbiter giving two requesters one-at-a-time access to an SRAM controller.
// Latency: issue one cycle after request; write done at WR_CYCLES+2; no backpressure, requests wait in IDLE.
module sram_arb #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int WR_CYCLES  = 8,
    parameter int RD_TIMEOUT = 64
) (
    input  logic       iClock,
    input  logic       iReset,
    sram_arb_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, DONE} state_t;

    localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);
    localparam logic [7:0] RD_LAST = 8'(RD_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              sel_q, sel_d;
    logic              err_q, err_d;
    logic              wr_q, wr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              win;

    // Under contention the requester that was not served last goes first.
    always_comb begin
        win = bus.iReq1;
        if (bus.iReq0 && bus.iReq1) begin
            win = ~last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        err_d   = err_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        case (state_q)
            IDLE: begin
                if (bus.iReq0 || bus.iReq1) begin
                    state_d = ISSUE;
                    sel_d   = win;
                    last_d  = win;
                    err_d   = 1'b0;
                    wr_d    = win ? bus.iWrite1  : bus.iWrite0;
                    addr_d  = win ? bus.iAddr1   : bus.iAddr0;
                    wdat_d  = win ? bus.iWrData1 : bus.iWrData0;
                end
            end
            ISSUE: begin
                cnt_d   = 8'd0;
                state_d = wr_q ? WAIT_WR : WAIT_RD;
            end
            WAIT_WR: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == WR_LAST) begin
                    state_d = DONE;
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + 8'd1;
                // Data arriving on the timeout cycle still counts as a good read.
                if (bus.iValidRead) begin
                    rdat_d  = bus.iRdData;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == RD_LAST) begin
                    rdat_d  = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
        end
    end

    assign bus.oGnt0         = (state_q != IDLE) && !sel_q;
    assign bus.oGnt1         = (state_q != IDLE) &&  sel_q;
    assign bus.oDone0        = (state_q == DONE) && !sel_q;
    assign bus.oDone1        = (state_q == DONE) &&  sel_q;
    assign bus.oErr          = (state_q == DONE) &&  err_q;
    assign bus.oValidRequest = (state_q == ISSUE);
    assign bus.oWrite        = wr_q;
    assign bus.oAddress      = addr_q;
    assign bus.oWrData       = wdat_q;
    assign bus.oRdData       = rdat_q;
endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: stimulus queues expected issues/completions, a negedge monitor checks them.
module tb_sram_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arb_if #(.ADDR_W(22), .DATA_W(16)) bus ();

    sram_arb #(.ADDR_W(22), .DATA_W(16), .WR_CYCLES(8), .RD_TIMEOUT(64)) dut (
        .iClock(clk),
        .iReset(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [21:0] addr;
        logic [15:0] wd;
        logic        wr;
        logic        id;
        int          cyc;
    } iss_t;

    typedef struct {
        logic        id;
        logic        err;
        logic [15:0] rd;
        int          cyc;
        int          glen;
    } done_t;

    iss_t        iss_q[$];
    done_t       done_q[$];
    logic [15:0] last_rd = 16'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_iss(input logic id, input logic wr, input logic [21:0] a,
                           input logic [15:0] d, input int c);
        iss_t e;
        e.addr = a; e.wd = d; e.wr = wr; e.id = id; e.cyc = c;
        iss_q.push_back(e);
    endtask

    // seen: cycle the request was sampled in IDLE; dc: cycle oDone is expected.
    task automatic exp_done(input logic id, input logic err, input logic [15:0] rd,
                            input int seen, input int dc);
        done_t e;
        e.id = id; e.err = err; e.rd = rd; e.cyc = dc; e.glen = dc - seen;
        done_q.push_back(e);
    endtask

    task automatic start(input logic id, input logic wr, input logic [21:0] a,
                         input logic [15:0] d, output int c);
        if (!id) begin
            bus.iReq0 = 1'b1; bus.iWrite0 = wr; bus.iAddr0 = a; bus.iWrData0 = d;
        end else begin
            bus.iReq1 = 1'b1; bus.iWrite1 = wr; bus.iAddr1 = a; bus.iWrData1 = d;
        end
        c = cyc;
        exp_iss(id, wr, a, d, c + 1);
    endtask

    // Drop the request and scramble its fields; the latched copy must not follow.
    task automatic drop(input logic id);
        if (!id) begin
            bus.iReq0 = 1'b0; bus.iWrite0 = ~bus.iWrite0;
            bus.iAddr0 = ~bus.iAddr0; bus.iWrData0 = ~bus.iWrData0;
        end else begin
            bus.iReq1 = 1'b0; bus.iWrite1 = ~bus.iWrite1;
            bus.iAddr1 = ~bus.iAddr1; bus.iWrData1 = ~bus.iWrData1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (iss_q.size() != 0 || done_q.size() != 0); i++) tick(1);
        chk("drain_pending", 64'(iss_q.size() + done_q.size()), 64'd0);
        tick(2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},  {bus.oGnt1, bus.oGnt0}, 2'b00);
        chk({tag, "_done"}, {bus.oDone1, bus.oDone0}, 2'b00);
        chk({tag, "_err"},  bus.oErr, 1'b0);
        chk({tag, "_vreq"}, bus.oValidRequest, 1'b0);
        chk({tag, "_wr"},   bus.oWrite, 1'b0);
        chk({tag, "_addr"}, bus.oAddress, 22'h0);
        chk({tag, "_wdat"}, bus.oWrData, 16'h0);
        chk({tag, "_rdat"}, bus.oRdData, 16'h0);
    endtask

    // Monitor: pops expectations whenever the DUT issues or completes.
    int   glen = 0;
    logic prev_vr = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            glen = 0;
            prev_vr = 1'b0;
        end else begin
            if (bus.oGnt0 || bus.oGnt1) begin
                glen++;
                chk("gnt_exclusive", bus.oGnt0 & bus.oGnt1, 1'b0);
            end
            if (bus.oValidRequest) begin
                if (iss_q.size() == 0) begin
                    chk("unexpected_issue", 1'b1, 1'b0);
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    chk("iss_cycle", 64'(cyc), 64'(e.cyc));
                    chk("iss_addr", bus.oAddress, e.addr);
                    chk("iss_wdat", bus.oWrData, e.wd);
                    chk("iss_write", bus.oWrite, e.wr);
                    chk("iss_gnt", {bus.oGnt1, bus.oGnt0}, e.id ? 2'b10 : 2'b01);
                    chk("iss_single_pulse", prev_vr, 1'b0);
                end
            end
            if (bus.oDone0 || bus.oDone1) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("done_id", {bus.oDone1, bus.oDone0}, e.id ? 2'b10 : 2'b01);
                    chk("done_gnt", {bus.oGnt1, bus.oGnt0}, e.id ? 2'b10 : 2'b01);
                    chk("done_err", bus.oErr, e.err);
                    chk("done_rdata", bus.oRdData, e.rd);
                    chk("gnt_length", 64'(glen), 64'(e.glen));
                end
                glen = 0;
            end
            prev_vr = bus.oValidRequest;
        end
    end

    initial begin
        int c;
        bus.iReq0 = 1'b0; bus.iReq1 = 1'b0; bus.iWrite0 = 1'b0; bus.iWrite1 = 1'b0;
        bus.iAddr0 = '0; bus.iAddr1 = '0; bus.iWrData0 = '0; bus.iWrData1 = '0;
        bus.iValidRead = 1'b0; bus.iRdData = '0;
        tick(3);
        chk_reset_outputs("rst");

        // Contention from reset release: 0,1,0,1 with 11-cycle spacing.
        bus.iReq0 = 1'b1; bus.iWrite0 = 1'b1; bus.iAddr0 = 22'h000AAA; bus.iWrData0 = 16'h1111;
        bus.iReq1 = 1'b1; bus.iWrite1 = 1'b1; bus.iAddr1 = 22'h000BBB; bus.iWrData1 = 16'h2222;
        rst_n = 1'b1;
        c = cyc;
        exp_iss(1'b0, 1'b1, 22'h000AAA, 16'h1111, c + 1);
        exp_iss(1'b1, 1'b1, 22'h000BBB, 16'h2222, c + 12);
        exp_iss(1'b0, 1'b1, 22'h000AAA, 16'h1111, c + 23);
        exp_iss(1'b1, 1'b1, 22'h000BBB, 16'h2222, c + 34);
        exp_done(1'b0, 1'b0, 16'h0, c,      c + 10);
        exp_done(1'b1, 1'b0, 16'h0, c + 11, c + 21);
        exp_done(1'b0, 1'b0, 16'h0, c + 22, c + 32);
        exp_done(1'b1, 1'b0, 16'h0, c + 33, c + 43);
        tick(35);
        drop(1'b0);
        drop(1'b1);
        drain();

        // Single write; latched fields must survive input changes.
        start(1'b0, 1'b1, 22'h000123, 16'hBEEF, c);
        exp_done(1'b0, 1'b0, last_rd, c, c + 10);
        tick(1);
        drop(1'b0);
        tick(3);
        chk("hold_addr", bus.oAddress, 22'h000123);
        chk("hold_wdat", bus.oWrData, 16'hBEEF);
        chk("hold_write", bus.oWrite, 1'b1);
        drain();

        // Read answered three cycles after issue.
        start(1'b1, 1'b0, 22'h3FFFFF, 16'hCAFE, c);
        exp_done(1'b1, 1'b0, 16'h1234, c, c + 5);
        last_rd = 16'h1234;
        tick(1);
        drop(1'b1);
        tick(3);
        bus.iValidRead = 1'b1; bus.iRdData = 16'h1234;
        tick(1);
        bus.iValidRead = 1'b0; bus.iRdData = 16'hFFFF;
        drain();

        // Read timeout, then a stray iValidRead in IDLE.
        start(1'b0, 1'b0, 22'h000042, 16'h0000, c);
        exp_done(1'b0, 1'b1, 16'h0000, c, c + 66);
        last_rd = 16'h0000;
        tick(1);
        drop(1'b0);
        drain();
        bus.iValidRead = 1'b1; bus.iRdData = 16'h7777;
        tick(1);
        bus.iValidRead = 1'b0;
        tick(3);
        chk("idle_valid_ignored", bus.oRdData, last_rd);

        // Read data on the timeout cycle wins.
        start(1'b1, 1'b0, 22'h000055, 16'h0000, c);
        exp_done(1'b1, 1'b0, 16'h5A5A, c, c + 66);
        last_rd = 16'h5A5A;
        tick(1);
        drop(1'b1);
        tick(64);
        bus.iValidRead = 1'b1; bus.iRdData = 16'h5A5A;
        tick(1);
        bus.iValidRead = 1'b0;
        drain();

        // Reset during WAIT_RD: abandoned, outputs cleared, requester 0 wins next contention.
        start(1'b0, 1'b0, 22'h000066, 16'h0000, c);
        tick(1);
        drop(1'b0);
        tick(5);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("midrst");
        last_rd = 16'h0000;
        bus.iReq0 = 1'b1; bus.iWrite0 = 1'b1; bus.iAddr0 = 22'h000C0C; bus.iWrData0 = 16'h3333;
        bus.iReq1 = 1'b1; bus.iWrite1 = 1'b1; bus.iAddr1 = 22'h000D0D; bus.iWrData1 = 16'h4444;
        tick(2);
        chk("midrst_no_pending", 64'(iss_q.size() + done_q.size()), 64'd0);
        rst_n = 1'b1;
        c = cyc;
        exp_iss(1'b0, 1'b1, 22'h000C0C, 16'h3333, c + 1);
        exp_iss(1'b1, 1'b1, 22'h000D0D, 16'h4444, c + 12);
        exp_done(1'b0, 1'b0, 16'h0, c,      c + 10);
        exp_done(1'b1, 1'b0, 16'h0, c + 11, c + 21);
        tick(1);
        drop(1'b0);
        tick(11);
        drop(1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
